// File: rtl/frv_bram_arbiter_pkg.sv
// Shared definitions for the FRV BRAM arbiter: port indices, response
// state encoding and the address-window decode helper.
package frv_bram_arbiter_pkg;

    localparam int PORT_IMEM = 0;
    localparam int PORT_DMEM = 1;
    localparam int NPORTS    = 2;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_PEND = 1'b1
    } rsp_state_t;

    // Unsigned 32-bit window test; addresses below the base wrap to large
    // offsets and therefore fall outside the window.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr - base) < size;
    endfunction

endpackage

// File: rtl/frv_bram_arb_rsp.sv
// Per-port response slot: tracks one outstanding response, its error flag,
// and returns fresh BRAM data in the first response cycle and the captured
// hold register afterwards until the core acknowledges.
module frv_bram_arb_rsp
    import frv_bram_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_acc_bram,
    input  logic        i_acc_err,
    input  logic        i_ack,
    input  logic [31:0] i_bram_rdata,
    output logic        o_recv,
    output logic        o_error,
    output logic [31:0] o_rdata
);

    rsp_state_t  r_state;
    rsp_state_t  w_state_nxt;
    logic        r_error;
    logic        r_fresh;
    logic [31:0] r_hold;
    logic        w_accept;

    assign w_accept = i_acc_bram | i_acc_err;

    // Response state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RSP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a new accept always (re)fills the slot, ack alone empties it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RSP_IDLE: if (w_accept)            w_state_nxt = RSP_PEND;
            RSP_PEND: if (i_ack && !w_accept)  w_state_nxt = RSP_IDLE;
            default:                           w_state_nxt = RSP_IDLE;
        endcase
    end

    // Error flag, first-cycle marker and hold-register capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_error <= 1'b0;
            r_fresh <= 1'b0;
            r_hold  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_error <= i_acc_err;
            end
            r_fresh <= i_acc_bram;
            if (r_fresh) begin
                r_hold <= i_bram_rdata;
            end
        end
    end

    assign o_recv  = (r_state == RSP_PEND);
    assign o_error = o_recv & r_error;
    assign o_rdata = (!o_recv || r_error) ? 32'h0 :
                     (r_fresh ? i_bram_rdata : r_hold);

endmodule

// File: rtl/frv_bram_arbiter.sv
// Shares one single-ported BRAM between the FRV imem and dmem channels.
// Out-of-window requests complete locally with an error response.
// Build option: define FRV_BRAM_ARB_RR_EN for round-robin arbitration;
// otherwise dmem has fixed priority over imem.
module frv_bram_arbiter
    import frv_bram_arbiter_pkg::*;
#(
    parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
    parameter logic [31:0] BRAM_SIZE = 32'h0001_0000
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        imem_req,
    output logic        imem_gnt,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_wdata,
    input  logic [31:0] imem_addr,
    output logic        imem_recv,
    input  logic        imem_ack,
    output logic        imem_error,
    output logic [31:0] imem_rdata,
    input  logic        dmem_req,
    output logic        dmem_gnt,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_addr,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,
    output logic        bram_cen,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic        bram_stall,
    input  logic [31:0] bram_rdata
);

    logic [NPORTS-1:0] w_req, w_wen, w_ack, w_recv, w_error;
    logic [NPORTS-1:0] w_free, w_inwin, w_cand, w_errg, w_win, w_acc_bram;
    logic [3:0]        w_strb  [NPORTS];
    logic [31:0]       w_wdata [NPORTS];
    logic [31:0]       w_addr  [NPORTS];
    logic [31:0]       w_rdata [NPORTS];
    logic              w_pick_dmem;

    assign w_req[PORT_IMEM]   = imem_req;
    assign w_wen[PORT_IMEM]   = imem_wen;
    assign w_ack[PORT_IMEM]   = imem_ack;
    assign w_strb[PORT_IMEM]  = imem_strb;
    assign w_wdata[PORT_IMEM] = imem_wdata;
    assign w_addr[PORT_IMEM]  = imem_addr;
    assign w_req[PORT_DMEM]   = dmem_req;
    assign w_wen[PORT_DMEM]   = dmem_wen;
    assign w_ack[PORT_DMEM]   = dmem_ack;
    assign w_strb[PORT_DMEM]  = dmem_strb;
    assign w_wdata[PORT_DMEM] = dmem_wdata;
    assign w_addr[PORT_DMEM]  = dmem_addr;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        // A slot can take a new request once its current response is consumed
        assign w_free[gi]     = !w_recv[gi] || w_ack[gi];
        assign w_inwin[gi]    = in_window(w_addr[gi], BRAM_BASE, BRAM_SIZE);
        assign w_cand[gi]     = w_req[gi] && w_inwin[gi] && w_free[gi];
        assign w_errg[gi]     = w_req[gi] && !w_inwin[gi] && w_free[gi];
        assign w_acc_bram[gi] = w_win[gi] && !bram_stall;

        frv_bram_arb_rsp u_rsp (
            .i_clk        (g_clk),
            .i_rst        (g_reset),
            .i_acc_bram   (w_acc_bram[gi]),
            .i_acc_err    (w_errg[gi]),
            .i_ack        (w_ack[gi]),
            .i_bram_rdata (bram_rdata),
            .o_recv       (w_recv[gi]),
            .o_error      (w_error[gi]),
            .o_rdata      (w_rdata[gi])
        );
    end

`ifdef FRV_BRAM_ARB_RR_EN
    logic r_prio_dmem;

    // Round-robin pointer: after an accepted access the other port is preferred
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_prio_dmem <= 1'b0;
        end else if (bram_cen && !bram_stall) begin
            r_prio_dmem <= w_win[PORT_IMEM];
        end
    end

    assign w_pick_dmem = w_cand[PORT_DMEM] && (!w_cand[PORT_IMEM] || r_prio_dmem);
`else
    assign w_pick_dmem = w_cand[PORT_DMEM];
`endif

    // Winner selection and BRAM request drive (zeroed when no candidate)
    always_comb begin
        w_win      = '0;
        bram_cen   = 1'b0;
        bram_addr  = 32'h0;
        bram_wdata = 32'h0;
        bram_wstrb = 4'b0000;
        if (w_pick_dmem) begin
            w_win[PORT_DMEM] = 1'b1;
        end else if (w_cand[PORT_IMEM]) begin
            w_win[PORT_IMEM] = 1'b1;
        end
        for (int p = 0; p < NPORTS; p++) begin
            if (w_win[p]) begin
                bram_cen   = 1'b1;
                bram_addr  = w_addr[p] - BRAM_BASE;
                bram_wdata = w_wdata[p];
                bram_wstrb = w_wen[p] ? w_strb[p] : 4'b0000;
            end
        end
    end

    assign imem_gnt   = w_errg[PORT_IMEM] | w_acc_bram[PORT_IMEM];
    assign dmem_gnt   = w_errg[PORT_DMEM] | w_acc_bram[PORT_DMEM];
    assign imem_recv  = w_recv[PORT_IMEM];
    assign dmem_recv  = w_recv[PORT_DMEM];
    assign imem_error = w_error[PORT_IMEM];
    assign dmem_error = w_error[PORT_DMEM];
    assign imem_rdata = w_rdata[PORT_IMEM];
    assign dmem_rdata = w_rdata[PORT_DMEM];

endmodule

// File: tb/tb_frv_bram_arbiter.sv
// Scoreboard bench for frv_bram_arbiter. Honours FRV_BRAM_ARB_RR_EN the same
// way as the design so the reference arbitration matches the build.
module tb_frv_bram_arbiter;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic [1:0]  req, wen, ack;
    logic [3:0]  strb  [2];
    logic [31:0] wdata [2];
    logic [31:0] addr  [2];
    logic        bram_stall;
    logic [31:0] bram_rdata;

    logic        imem_gnt, dmem_gnt, imem_recv, dmem_recv, imem_error, dmem_error;
    logic [31:0] imem_rdata, dmem_rdata, bram_addr, bram_wdata;
    logic        bram_cen;
    logic [3:0]  bram_wstrb;

    logic [1:0]  gnt, recv, err;
    logic [31:0] rdata [2];
    assign gnt      = {dmem_gnt, imem_gnt};
    assign recv     = {dmem_recv, imem_recv};
    assign err      = {dmem_error, imem_error};
    assign rdata[0] = imem_rdata;
    assign rdata[1] = dmem_rdata;

    frv_bram_arbiter #(.BRAM_BASE(BASE), .BRAM_SIZE(SIZE)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .imem_req(req[0]), .imem_gnt(imem_gnt), .imem_wen(wen[0]), .imem_strb(strb[0]),
        .imem_wdata(wdata[0]), .imem_addr(addr[0]), .imem_recv(imem_recv), .imem_ack(ack[0]),
        .imem_error(imem_error), .imem_rdata(imem_rdata),
        .dmem_req(req[1]), .dmem_gnt(dmem_gnt), .dmem_wen(wen[1]), .dmem_strb(strb[1]),
        .dmem_wdata(wdata[1]), .dmem_addr(addr[1]), .dmem_recv(dmem_recv), .dmem_ack(ack[1]),
        .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .bram_cen(bram_cen), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_wstrb(bram_wstrb), .bram_stall(bram_stall), .bram_rdata(bram_rdata)
    );

    always #5 g_clk = ~g_clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
    endfunction

    // ---------------- external BRAM device model ----------------
    logic [31:0] mem [16];
    always @(posedge g_clk or posedge g_reset) begin : bram_dev
        if (g_reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            bram_rdata <= 32'h0;
        end else if (bram_cen && !bram_stall) begin
            bram_rdata <= mem[bram_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (bram_wstrb[b]) mem[bram_addr[5:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
        end else begin
            bram_rdata <= $urandom;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_mem [16];
    logic [1:0]  exp_pend;
    logic        rr_pref;     // 1: dmem preferred on a tie
    logic [1:0]  exp_gnt = 2'b00;
    logic [1:0]  exp_win = 2'b00;
    logic        exp_cen = 1'b0;
    rsp_t        q_i [$];
    rsp_t        q_d [$];

    // Arbitration rules evaluated from the current request picture
    always @(negedge g_clk) begin : arb_chk
        logic [1:0]  inw, fr, cand, errg;
        int          w;
        if (g_reset) begin
            exp_gnt = 2'b00;
            exp_win = 2'b00;
            exp_cen = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                inw[p]  = (addr[p] - BASE) < SIZE;
                fr[p]   = !exp_pend[p] || ack[p];
                cand[p] = req[p] && inw[p] && fr[p];
                errg[p] = req[p] && !inw[p] && fr[p];
            end
`ifdef FRV_BRAM_ARB_RR_EN
            exp_win = (cand == 2'b11) ? (rr_pref ? 2'b10 : 2'b01) : cand;
`else
            exp_win = (cand == 2'b11) ? 2'b10 : cand;
`endif
            exp_cen = |cand;
            exp_gnt = errg | (bram_stall ? 2'b00 : exp_win);
            chk("imem_gnt", 32'(imem_gnt), 32'(exp_gnt[0]));
            chk("dmem_gnt", 32'(dmem_gnt), 32'(exp_gnt[1]));
            chk("bram_cen", 32'(bram_cen), 32'(exp_cen));
            if (exp_cen) begin
                w = exp_win[1] ? 1 : 0;
                chk("bram_addr", bram_addr, addr[w] - BASE);
                chk("bram_wdata", bram_wdata, wdata[w]);
                chk("bram_wstrb", 32'(bram_wstrb), 32'(wen[w] ? strb[w] : 4'b0000));
            end else begin
                chk("bram_idle_wstrb", 32'(bram_wstrb), 32'h0);
                chk("bram_idle_addr", bram_addr, 32'h0);
            end
        end
    end

    // Commit accepted requests: queue expected responses, update memory image
    always @(posedge g_clk or posedge g_reset) begin : model_commit
        rsp_t        r;
        logic [31:0] off;
        if (g_reset) begin
            exp_pend = 2'b00;
            rr_pref  = 1'b0;
            for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (exp_gnt[p]) begin
                    if (exp_win[p]) begin
                        off    = addr[p] - BASE;
                        r.err  = 1'b0;
                        r.data = exp_mem[off[5:2]];
                        if (wen[p])
                            for (int b = 0; b < 4; b++)
                                if (strb[p][b]) exp_mem[off[5:2]][8*b +: 8] = wdata[p][8*b +: 8];
                    end else begin
                        r.err  = 1'b1;
                        r.data = 32'h0;
                    end
                    if (p == 0) q_i.push_back(r); else q_d.push_back(r);
                    exp_pend[p] = 1'b1;
                end else if (ack[p]) begin
                    exp_pend[p] = 1'b0;
                end
            end
            if (exp_cen && !bram_stall) rr_pref = exp_win[0];
        end
    end

    // ---------------- response monitor ----------------
    int rd_i = 0;
    int rd_d = 0;
    always @(negedge g_clk) begin : rsp_mon
        int   sz, idx;
        rsp_t e;
        if (g_reset) begin
            chk("rst_imem_recv", 32'(imem_recv), 32'h0);
            chk("rst_dmem_recv", 32'(dmem_recv), 32'h0);
            chk("rst_imem_error", 32'(imem_error), 32'h0);
            chk("rst_dmem_error", 32'(dmem_error), 32'h0);
            chk("rst_imem_rdata", imem_rdata, 32'h0);
            chk("rst_dmem_rdata", dmem_rdata, 32'h0);
            rd_i = q_i.size();
            rd_d = q_d.size();
        end else begin
            for (int p = 0; p < 2; p++) begin
                sz  = (p == 0) ? q_i.size() : q_d.size();
                idx = (p == 0) ? rd_i : rd_d;
                chk((p == 0) ? "imem_recv" : "dmem_recv", 32'(recv[p]), 32'(idx < sz));
                if (recv[p] && idx < sz) begin
                    e = (p == 0) ? q_i[idx] : q_d[idx];
                    chk((p == 0) ? "imem_error" : "dmem_error", 32'(err[p]), 32'(e.err));
                    chk((p == 0) ? "imem_rdata" : "dmem_rdata", rdata[p], e.data);
                    if (ack[p]) idx++;
                end
                if (p == 0) rd_i = idx; else rd_d = idx;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic we, input logic [3:0] s,
                            input logic [31:0] d, input logic [31:0] a);
        req[p] = r; wen[p] = we; strb[p] = s; wdata[p] = d; addr[p] = a;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k < 7)       return BASE + 32'($urandom_range(0, 15)) * 4;
        else if (k == 7) return BASE + SIZE - 4;
        else if (k == 8) return BASE + SIZE + 32'($urandom_range(0, 63)) * 4;
        else             return 32'hFFFF_FFFC;
    endfunction

    task automatic rand_cycle();
        for (int p = 0; p < 2; p++) begin
            if (!(req[p] && !exp_gnt[p]))
                set_port(p, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                         4'($urandom), $urandom, rand_addr());
            ack[p] = ($urandom_range(0, 9) < 7);
        end
        bram_stall = ($urandom_range(0, 3) == 0);
    endtask

    task automatic drain();
        req = 2'b00; ack = 2'b11; bram_stall = 1'b0;
        repeat (3) tick();
        ack = 2'b00;
    endtask

    initial begin
        req = 2'b00; wen = 2'b00; ack = 2'b00; bram_stall = 1'b0;
        for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge g_clk);
        #1 g_reset = 1'b0;
        tick();

        // Single dmem read at 0x10, ack held off for three response cycles
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h10);
        tick();
        req[1] = 1'b0;
        repeat (3) tick();
        ack[1] = 1'b1;
        tick();
        drain();

        // Both ports stream in-window reads with ack tied high
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h8);
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h1C);
        ack = 2'b11;
        repeat (8) tick();
        drain();

        // imem out of window alongside a dmem BRAM access
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h0, BASE + SIZE);
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h4);
        tick();
        drain();

        // dmem partial write held through a two-cycle stall
        set_port(1, 1'b1, 1'b1, 4'b0011, 32'h1234_5678, BASE + 32'h20);
        bram_stall = 1'b1;
        repeat (2) tick();
        bram_stall = 1'b0;
        tick();
        req[1] = 1'b0;
        tick();
        drain();
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h20);
        tick();
        drain();

        // dmem blocked by its own unacked response; imem takes the BRAM
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h30);
        tick();
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h34);
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h38);
        tick();
        req[0] = 1'b0;
        ack = 2'b10;
        tick();
        req[1] = 1'b0;
        drain();

        // Reset while a dmem response is pending, mid-cycle
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h3C);
        tick();
        req[1] = 1'b0;
        @(posedge g_clk);
        #2 g_reset = 1'b1;
        #5 g_reset = 1'b0;
        tick();
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0, BASE + 32'h10);
        tick();
        drain();

        // Randomized traffic
        repeat (3000) begin
            rand_cycle();
            tick();
        end
        drain();
        repeat (2) tick();

        @(negedge g_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
